stack_access_ctrl: RTL and testbench

Request/response front end for the push-down stack. It accepts push, pop and clear commands over a valid/ready handshake and checks every command against a local occupancy count, so illegal operations are rejected without touching the stack. It drives the stack's one-cycle enable, direction and clear strobes, and returns popped data or an error on a valid/ready response channel. It sits directly upstream of the stack and is its only driver.

---
 rtl/stack_access_ctrl_pkg.sv | 25 ++
 rtl/stack_access_ctrl_if.sv | 27 ++
 rtl/stack_access_ctrl_depth.sv | 51 +++++
 rtl/stack_access_ctrl.sv | 159 +++++++++++++++
 tb/tb_stack_access_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/stack_access_ctrl_pkg.sv
// Shared types and helpers for the stack access controller.
package stack_ctrl_pkg;

  localparam int unsigned DATAWIDTH_DEF = 8;
  localparam int unsigned ADDRWIDTH_DEF = 10;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_RSVD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  // One address is sacrificed so that full and empty are distinguishable.
  function automatic int unsigned capacity(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/stack_access_ctrl_if.sv
// Command/response handshake between a requester and the stack access controller.
interface stack_access_ctrl_if
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
);

  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [1:0]           req_op_i;
  logic [DATAWIDTH-1:0] req_data_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DATAWIDTH-1:0] rsp_data_o;
  logic                 rsp_err_o;

  modport master (
    output req_valid_i, req_op_i, req_data_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_data_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

endinterface

// File: rtl/stack_access_ctrl_depth.sv
// Local occupancy counter mirroring the stack, with registered empty/full flags.
module stack_depth_counter
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = ADDRWIDTH_DEF
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic               clr_i,
  output logic [ADDRWIDTH:0] count_o,
  output logic               is_empty_o,
  output logic               is_full_o
);

  localparam int unsigned     CW  = ADDRWIDTH + 1;
  localparam logic [CW-1:0]   CAP = CW'(capacity(ADDRWIDTH));

  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i) begin
      count_d = count_q + CW'(1);
    end else if (dec_i && !inc_i) begin
      count_d = count_q - CW'(1);
    end
  end

  // Flags derive from the next count so they line up with count_q.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CAP);
    end
  end

  assign count_o    = count_q;
  assign is_empty_o = empty_q;
  assign is_full_o  = full_q;

endmodule

// File: rtl/stack_access_ctrl.sv
// Front end for the push-down stack: validates commands against a local depth
// count, strobes the stack, and returns popped data or an error.
module stack_access_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
  parameter int unsigned ADDRWIDTH = ADDRWIDTH_DEF
) (
  input  logic                 Clk,
  input  logic                 Rst,
  stack_access_ctrl_if.slave   bus,
  output logic [ADDRWIDTH:0]   depth_o,
  output logic                 sync_err_o,
  output logic                 stk_rst_o,
  output logic                 stk_pushpop_o,
  output logic                 stk_en_o,
  output logic [DATAWIDTH-1:0] stk_data_o,
  input  logic [DATAWIDTH-1:0] stk_data_i,
  input  logic                 stk_empty_i,
  input  logic                 stk_full_i
);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 sync_err_q, sync_err_d;
  logic                 stk_rst_q, stk_rst_d;
  logic                 stk_en_q, stk_en_d;
  logic                 stk_pushpop_q, stk_pushpop_d;
  logic [DATAWIDTH-1:0] stk_data_q, stk_data_d;

  logic cnt_empty, cnt_full;
  logic accept_c, cmd_err_c, sync_mismatch_c;
  op_e  req_op_c;

  stack_depth_counter #(.ADDRWIDTH(ADDRWIDTH)) u_depth (
    .Clk        (Clk),
    .Rst        (Rst),
    .inc_i      (state_q == ISSUE && op_q == OP_PUSH),
    .dec_i      (state_q == ISSUE && op_q == OP_POP),
    .clr_i      (state_q == ISSUE && op_q == OP_CLEAR),
    .count_o    (depth_o),
    .is_empty_o (cnt_empty),
    .is_full_o  (cnt_full)
  );

  assign req_op_c        = op_e'(bus.req_op_i);
  assign accept_c        = bus.req_valid_i && req_ready_q;
  assign cmd_err_c       = (req_op_c == OP_RSVD) ||
                           (req_op_c == OP_POP  && cnt_empty) ||
                           (req_op_c == OP_PUSH && cnt_full);
  assign sync_mismatch_c = (stk_empty_i != cnt_empty) || (stk_full_i != cnt_full);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    sync_err_d    = sync_err_q;
    stk_rst_d     = 1'b1;
    stk_en_d      = 1'b0;
    stk_pushpop_d = stk_pushpop_q;
    stk_data_d    = stk_data_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (sync_mismatch_c) sync_err_d = 1'b1;
        if (accept_c) begin
          op_d        = req_op_c;
          req_ready_d = 1'b0;
          if (cmd_err_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d = ISSUE;
            case (req_op_c)
              OP_PUSH: begin
                stk_en_d      = 1'b1;
                stk_pushpop_d = 1'b0;
                stk_data_d    = bus.req_data_i;
              end
              OP_POP: begin
                stk_en_d      = 1'b1;
                stk_pushpop_d = 1'b1;
              end
              OP_CLEAR: stk_rst_d = 1'b0;
              default:  stk_rst_d = 1'b1;
            endcase
          end
        end
      end
      ISSUE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = (op_q == OP_POP) ? stk_data_i : '0;
        if (op_q == OP_CLEAR) sync_err_d = 1'b0;
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset holds the stack cleared and drops any in-flight command.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q       <= IDLE;
      op_q          <= OP_PUSH;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      sync_err_q    <= 1'b0;
      stk_rst_q     <= 1'b0;
      stk_en_q      <= 1'b0;
      stk_pushpop_q <= 1'b0;
      stk_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      sync_err_q    <= sync_err_d;
      stk_rst_q     <= stk_rst_d;
      stk_en_q      <= stk_en_d;
      stk_pushpop_q <= stk_pushpop_d;
      stk_data_q    <= stk_data_d;
    end
  end

  assign bus.req_ready_o = req_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign sync_err_o      = sync_err_q;
  assign stk_rst_o       = stk_rst_q;
  assign stk_en_o        = stk_en_q;
  assign stk_pushpop_o   = stk_pushpop_q;
  assign stk_data_o      = stk_data_q;

endmodule

// File: tb/tb_stack_access_ctrl.sv
// Scoreboard bench for stack_access_ctrl with a behavioural stack and LIFO reference.
module tb_stack_access_ctrl;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 10;
  localparam int          CAP = 1023;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         depth;
    logic       sync;
    int         acc;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst;
  logic [AW:0]   depth_o;
  logic          sync_err_o, stk_rst_o, stk_pushpop_o, stk_en_o;
  logic [DW-1:0] stk_data_o, stk_data_i;
  logic          stk_empty_i, stk_full_i;

  stack_access_ctrl_if #(.DATAWIDTH(DW)) bus ();

  stack_access_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus), .depth_o(depth_o), .sync_err_o(sync_err_o),
    .stk_rst_o(stk_rst_o), .stk_pushpop_o(stk_pushpop_o), .stk_en_o(stk_en_o),
    .stk_data_o(stk_data_o), .stk_data_i(stk_data_i),
    .stk_empty_i(stk_empty_i), .stk_full_i(stk_full_i)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rst_quiet = 0;
  exp_t sbq[$];
  logic [7:0] ref_q[$];
  logic exp_sync = 1'b0;
  int   last_acc = -100;
  logic [1:0] last_op = 2'b00;
  logic [7:0] last_data = 8'h00;
  logic last_legal = 1'b0;
  logic force_ne = 1'b0;
  int   rdy_mode = 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Behavioural stack sitting downstream of the controller.
  logic [7:0] smem [0:1023];
  int sp = 0;
  always @(posedge Clk) begin
    if (!stk_rst_o) sp <= 0;
    else if (stk_en_o) begin
      if (!stk_pushpop_o) begin
        if (sp < 1024) begin smem[sp] <= stk_data_o; sp <= sp + 1; end
      end else if (sp > 0) sp <= sp - 1;
    end
  end
  assign stk_data_i  = (sp > 0) ? smem[sp-1] : 8'h00;
  assign stk_empty_i = force_ne ? 1'b0 : (sp == 0);
  assign stk_full_i  = (sp == CAP);

  always @(posedge Clk) begin
    cyc       <= cyc + 1;
    rst_quiet <= Rst ? rst_quiet + 1 : 0;
  end

  initial bus.rsp_ready_i = 1'b1;
  always @(posedge Clk) begin
    #1;
    case (rdy_mode)
      0:       bus.rsp_ready_i = 1'b0;
      1:       bus.rsp_ready_i = 1'b1;
      default: bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: response scoreboard, hold stability and stack strobe checks.
  logic prev_valid = 1'b0;
  logic [7:0] hold_data;
  logic hold_err;
  int vstart = 0;
  always @(negedge Clk) begin
    exp_t e;
    if (Rst === 1'b1) begin
      if (bus.rsp_valid_o && !prev_valid) begin
        vstart = cyc; hold_data = bus.rsp_data_o; hold_err = bus.rsp_err_o;
      end
      if (bus.rsp_valid_o) begin
        check("ready_low_in_resp", 64'(bus.req_ready_o), 64'd0);
        if (prev_valid) begin
          check("rsp_data_hold", 64'(bus.rsp_data_o), 64'(hold_data));
          check("rsp_err_hold", 64'(bus.rsp_err_o), 64'(hold_err));
        end
        if (bus.rsp_ready_i) begin
          if (sbq.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
          else begin
            e = sbq.pop_front();
            check("rsp_data", 64'(bus.rsp_data_o), 64'(e.data));
            check("rsp_err", 64'(bus.rsp_err_o), 64'(e.err));
            check("depth", 64'(depth_o), 64'(e.depth));
            check("sync_err", 64'(sync_err_o), 64'(e.sync));
            check("rsp_latency", 64'(vstart - e.acc), e.err ? 64'd1 : 64'd2);
          end
        end
      end
      prev_valid = bus.rsp_valid_o;
      if (rst_quiet >= 2) begin
        if (stk_en_o) begin
          check("strobe_cycle", 64'(cyc - last_acc), 64'd1);
          check("strobe_legal", 64'(last_legal), 64'd1);
          check("strobe_dir", 64'(stk_pushpop_o), 64'(last_op == 2'b01));
          check("strobe_clr_overlap", 64'(stk_rst_o), 64'd1);
          if (!stk_pushpop_o) check("strobe_data", 64'(stk_data_o), 64'(last_data));
        end
        if (!stk_rst_o) begin
          check("clr_cycle", 64'(cyc - last_acc), 64'd1);
          check("clr_op", 64'(last_op), 64'd3);
        end
      end
    end else prev_valid = 1'b0;
  end

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    exp_t e;
    int n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 100) begin @(negedge Clk); n++; end
    if (n >= 100) begin check("ready_timeout", 64'd0, 64'd1); return; end
    e.acc = cyc; e.data = 8'h00; e.err = 1'b0; e.sync = exp_sync;
    case (op)
      2'b00: if (ref_q.size() == CAP) e.err = 1'b1; else ref_q.push_back(d);
      2'b01: if (ref_q.size() == 0) e.err = 1'b1; else e.data = ref_q.pop_back();
      2'b10: e.err = 1'b1;
      default: begin ref_q.delete(); exp_sync = 1'b0; e.sync = 1'b0; end
    endcase
    e.depth = ref_q.size();
    last_acc = cyc; last_op = op; last_data = d; last_legal = !e.err;
    sbq.push_back(e);
    bus.req_valid_i = 1'b1; bus.req_op_i = op; bus.req_data_i = d;
    @(negedge Clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || bus.rsp_valid_o) && n < 300) begin @(negedge Clk); n++; end
    if (n >= 300) check("drain_timeout", 64'd0, 64'd1);
    @(negedge Clk);
  endtask

  initial begin
    int r;
    Rst = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_op_i = 2'b00; bus.req_data_i = 8'h00;
    repeat (3) begin
      @(negedge Clk);
      check("reset_outputs",
            64'({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_err_o, depth_o,
                 sync_err_o, stk_en_o, stk_pushpop_o, stk_data_o, stk_rst_o}), 64'd0);
    end
    @(posedge Clk); #2 Rst = 1'b1;
    @(posedge Clk); @(negedge Clk);
    check("ready_after_reset", 64'(bus.req_ready_o), 64'd1);

    send(2'b00, 8'hA5); drain();
    send(2'b01, 8'h00); drain();
    send(2'b01, 8'h00); drain();           // pop on empty
    send(2'b10, 8'h11); drain();           // reserved op
    send(2'b00, 8'h01); send(2'b00, 8'h02); send(2'b00, 8'h03);
    send(2'b11, 8'h00); send(2'b01, 8'h00); drain();

    // Backpressure: response must hold while rsp_ready_i is low.
    rdy_mode = 0;
    send(2'b00, 8'h5A);
    repeat (6) @(negedge Clk);
    check("held_valid", 64'(bus.rsp_valid_o), 64'd1);
    check("held_data", 64'(bus.rsp_data_o), 64'd0);
    rdy_mode = 1; drain();
    send(2'b01, 8'h00); drain();

    // Stack flags disagreeing with the local count latch sync_err_o until clear.
    force_ne = 1'b1;
    repeat (3) @(negedge Clk);
    check("sync_set", 64'(sync_err_o), 64'd1);
    force_ne = 1'b0; exp_sync = 1'b1;
    send(2'b00, 8'h77); drain();
    send(2'b11, 8'h00); drain();
    check("sync_cleared", 64'(sync_err_o), 64'd0);

    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 48)      send(2'b00, 8'($urandom));
      else if (r < 88) send(2'b01, 8'h00);
      else if (r < 94) send(2'b10, 8'($urandom));
      else             send(2'b11, 8'h00);
    end
    rdy_mode = 1; drain();

    send(2'b11, 8'h00);
    for (int i = 0; i < CAP; i++) send(2'b00, 8'($urandom));
    drain();
    check("depth_full", 64'(depth_o), 64'(CAP));
    send(2'b00, 8'hEE); drain();           // push when full
    for (int i = 0; i < 4; i++) send(2'b01, 8'h00);
    drain();

    // Reset while a command is in flight drops it silently.
    send(2'b00, 8'h3C);
    @(posedge Clk); #2 Rst = 1'b0;
    sbq.delete(); ref_q.delete(); exp_sync = 1'b0;
    repeat (2) @(negedge Clk);
    check("midrst_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
    check("midrst_depth", 64'(depth_o), 64'd0);
    @(posedge Clk); #2 Rst = 1'b1;
    repeat (2) @(negedge Clk);
    check("midrst_ready", 64'(bus.req_ready_o), 64'd1);
    send(2'b01, 8'h00); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
